// File: rtl/aes_cipher_collector.sv
// Receive-side collector for the AES-GCM result stream: rebuilds packet framing from the bypass length field and buffers words in a show-ahead FIFO.
// Optional statistics outputs (o_pkt_count, o_drop_count) are built when AES_COLLECTOR_STATS_EN is defined.
module aes_cipher_collector #(
  parameter int DEPTH          = 8,
  parameter int BYTES_PER_WORD = 52
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_cp_ready,
  input  logic [0:127]   i_cipher_text,
  input  logic [288:0]   i_bypass_text,
  output logic           o_valid,
  input  logic           i_ready,
  output logic [416:0]   o_data,
  output logic           o_first,
  output logic           o_last,
  output logic           o_overflow,
`ifdef AES_COLLECTOR_STATS_EN
  output logic [31:0]    o_pkt_count,
  output logic [15:0]    o_drop_count,
`endif
  output logic           o_dbg_state
);

  // Handshake: i_cp_ready is a push strobe with no backpressure; a word leaves
  // the FIFO on every cycle where o_valid && i_ready, and i_ready is ignored
  // while o_valid is low.

  localparam int          PW  = $clog2(DEPTH);
  localparam logic [15:0] BPW = BYTES_PER_WORD[15:0];

  typedef enum logic {ST_IDLE = 1'b0, ST_BODY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [15:0]   rem_q, rem_d;
  logic [15:0]   len;
  logic          word_first, word_last;

  logic [418:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, wr_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q;
  logic          full, empty, pop, accept, drop;
  logic [418:0]  head;

  assign len = i_bypass_text[48:33];

  // Framing FSM: state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Framing FSM: next state; the FSM advances on every strobe, dropped or not
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (i_cp_ready) begin
      case (state_q)
        ST_IDLE: begin
          if (len <= BPW) begin
            rem_d = len;
          end else begin
            rem_d   = len - BPW;
            state_d = ST_BODY;
          end
        end
        ST_BODY: begin
          if (rem_q <= BPW) begin
            state_d = ST_IDLE;
          end else begin
            rem_d = rem_q - BPW;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Framing FSM: per-word flags
  always_comb begin
    word_first = 1'b0;
    word_last  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        word_first = 1'b1;
        word_last  = (len <= BPW);
      end
      ST_BODY: word_last = (rem_q <= BPW);
      default: ;
    endcase
  end

  assign o_dbg_state = state_q;

  assign full   = (count_q == DEPTH[PW:0]);
  assign empty  = (count_q == '0);
  assign pop    = !empty && i_ready;
  assign accept = i_cp_ready && (!full || pop);
  assign drop   = i_cp_ready && full && !pop;
  assign count_d = count_q + {{PW{1'b0}}, accept} - {{PW{1'b0}}, pop};

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (drop)   ovf_q    <= 1'b1;
    end
  end

  // Storage is not reset; outputs are gated by occupancy instead.
  always_ff @(posedge clk) begin
    if (!reset && accept) begin
      mem_q[wr_ptr_q] <= {word_first, word_last, i_cipher_text, i_bypass_text};
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign o_valid    = !empty;
  assign o_data     = empty ? '0 : head[416:0];
  assign o_first    = !empty && head[418];
  assign o_last     = !empty && head[417];
  assign o_overflow = ovf_q;

`ifdef AES_COLLECTOR_STATS_EN
  logic [31:0] pkt_count_q;
  logic [15:0] drop_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q  <= '0;
      drop_count_q <= '0;
    end else begin
      if (pop && head[417]) pkt_count_q <= pkt_count_q + 32'd1;
      if (drop && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
    end
  end

  assign o_pkt_count  = pkt_count_q;
  assign o_drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_aes_cipher_collector.sv
// Self-checking bench for aes_cipher_collector: directed scenarios plus random traffic against a packet-level reference model.
module tb_aes_cipher_collector;

  localparam int DEPTH = 8;
  localparam int BPW   = 52;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           i_cp_ready = 1'b0;
  logic [0:127]   i_cipher_text = '0;
  logic [288:0]   i_bypass_text = '0;
  logic           i_ready = 1'b0;
  logic           o_valid, o_first, o_last, o_overflow, o_dbg_state;
  logic [416:0]   o_data;
`ifdef AES_COLLECTOR_STATS_EN
  logic [31:0]    o_pkt_count;
  logic [15:0]    o_drop_count;
`endif

  aes_cipher_collector #(.DEPTH(DEPTH), .BYTES_PER_WORD(BPW)) dut (
    .clk(clk), .reset(reset), .i_cp_ready(i_cp_ready),
    .i_cipher_text(i_cipher_text), .i_bypass_text(i_bypass_text),
    .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data),
    .o_first(o_first), .o_last(o_last), .o_overflow(o_overflow),
`ifdef AES_COLLECTOR_STATS_EN
    .o_pkt_count(o_pkt_count), .o_drop_count(o_drop_count),
`endif
    .o_dbg_state(o_dbg_state)
  );

  always #5 clk = ~clk;

  // Reference model: FIFO of {first, last, data} plus words left in current packet
  logic [418:0] exp_q[$];
  int           words_left;
  logic         exp_ovf;
  int unsigned  exp_pkts;
  int unsigned  exp_drops;
  int           n_checks = 0;
  int           n_errors = 0;

  task automatic check(input string tag, input logic [416:0] obs, input logic [416:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [288:0] mk_bypass(input int len);
    logic [288:0] b;
    for (int i = 0; i < 10; i++) b[i*32 +: 32] = $urandom;
    b[288] = 1'($urandom_range(0, 1));
    b[48:33] = 16'(len);
    return b;
  endfunction

  function automatic logic [127:0] mk_cipher();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic compare_outputs();
    logic [418:0] h;
    check("valid", 417'(o_valid), 417'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      h = exp_q[0];
      check("data", o_data, h[416:0]);
      check("first", 417'(o_first), 417'(h[418]));
      check("last", 417'(o_last), 417'(h[417]));
    end else begin
      check("data_idle", o_data, '0);
      check("first_idle", 417'(o_first), '0);
      check("last_idle", 417'(o_last), '0);
    end
    check("overflow", 417'(o_overflow), 417'(exp_ovf));
    check("in_packet", 417'(o_dbg_state), 417'(words_left > 0));
`ifdef AES_COLLECTOR_STATS_EN
    check("pkt_count", 417'(o_pkt_count), 417'(exp_pkts));
    check("drop_count", 417'(o_drop_count), 417'(exp_drops));
`endif
  endtask

  // One clock cycle: drive, advance the model at the edge, then compare.
  task automatic step(input logic strobe, input int len, input logic rdy);
    logic [127:0] c;
    logic [288:0] b;
    logic         pop, first, last;
    int           nwords;
    @(negedge clk);
    c = mk_cipher();
    b = mk_bypass(len);
    i_cp_ready    = strobe;
    i_cipher_text = c;
    i_bypass_text = b;
    i_ready       = rdy;
    @(posedge clk);
    pop = (exp_q.size() > 0) && rdy;
    first = 1'b0;
    last  = 1'b0;
    if (strobe) begin
      if (words_left == 0) begin
        nwords = (len == 0) ? 1 : (len + BPW - 1) / BPW;
        first = 1'b1;
        words_left = nwords - 1;
      end else begin
        words_left--;
      end
      last = (words_left == 0);
    end
    if (pop) begin
      if (exp_q[0][417]) exp_pkts++;
      void'(exp_q.pop_front());
    end
    if (strobe) begin
      if (exp_q.size() < DEPTH) exp_q.push_back({first, last, c, b});
      else begin
        exp_ovf = 1'b1;
        if (exp_drops < 16'hFFFF) exp_drops++;
      end
    end
    #1;
    compare_outputs();
  endtask

  task automatic do_reset(input logic strobe_too);
    @(negedge clk);
    reset         = 1'b1;
    i_cp_ready    = strobe_too;
    i_bypass_text = mk_bypass(10);
    i_ready       = 1'b1;
    @(posedge clk);
    exp_q.delete();
    words_left = 0;
    exp_ovf    = 1'b0;
    exp_pkts   = 0;
    exp_drops  = 0;
    #1;
    compare_outputs();
    @(negedge clk);
    reset      = 1'b0;
    i_cp_ready = 1'b0;
    i_ready    = 1'b0;
  endtask

  initial begin
    words_left = 0;
    exp_ovf    = 1'b0;
    exp_pkts   = 0;
    exp_drops  = 0;

    do_reset(1'b0);

    // Single-word packet, visible for exactly one cycle
    step(1'b1, 40, 1'b1);
    check("single_first_last", 417'({o_first, o_last}), 417'(2'b11));
    step(1'b0, 0, 1'b1);

    // Three-word packet followed by a short one
    step(1'b1, 150, 1'b0);
    step(1'b1, 0, 1'b0);
    step(1'b1, 0, 1'b0);
    step(1'b1, 10, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);

    // len == 0 and exact multiples of the word size
    step(1'b1, 0, 1'b1);
    step(1'b1, 104, 1'b1);
    step(1'b1, 0, 1'b1);
    step(1'b0, 0, 1'b1);

    // Nine strobes into a stalled FIFO, then drain
    for (int i = 0; i < 9; i++) step(1'b1, 10, 1'b0);
    check("overflow_sticky", 417'(o_overflow), 417'(1'b1));
    for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b1);
    do_reset(1'b0);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1'b1, 30, 1'b0);
    step(1'b1, 30, 1'b1);
    step(1'b1, 30, 1'b1);
    check("full_pushpop_no_ovf", 417'(o_overflow), 417'(1'b0));
    for (int i = 0; i < 9; i++) step(1'b0, 0, 1'b1);

    // Reset mid-packet with a strobe in the reset cycle
    step(1'b1, 200, 1'b0);
    step(1'b1, 0, 1'b0);
    do_reset(1'b1);
    step(1'b1, 52, 1'b1);
    check("after_reset_first_last", 417'({o_first, o_last}), 417'(2'b11));
    step(1'b0, 0, 1'b1);

    // Counter scenario: 10 single-word packets into a stalled FIFO, drain 3
    do_reset(1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 20, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b0);
    do_reset(1'b0);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom_range(0, 320), ($urandom_range(0, 2) != 0));
      if (i % 500 == 499) do_reset(1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
